// File: rtl/direct_mapped_cache_if.sv
// direct_mapped_cache_if: CPU-side and memory-side signals of the direct-mapped cache
interface direct_mapped_cache_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 13,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_dataIn;
  logic              cpu_read;
  logic              cpu_write;
  logic              flush;
  logic [DATA_W-1:0] cpu_dataOut;
  logic              cpu_done;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_dataIn;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_dataOut;
  logic              mem_done;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;
  modport slave (
    input  cpu_address, cpu_dataIn, cpu_read, cpu_write, flush, mem_dataOut, mem_done,
    output cpu_dataOut, cpu_done, mem_address, mem_dataIn, mem_read, mem_write, hit_count, miss_count
  );
  modport master (
    output cpu_address, cpu_dataIn, cpu_read, cpu_write, flush, mem_dataOut, mem_done,
    input  cpu_dataOut, cpu_done, mem_address, mem_dataIn, mem_read, mem_write, hit_count, miss_count
  );
endinterface

// File: rtl/direct_mapped_cache.sv
// direct_mapped_cache: write-through direct-mapped cache with flush and hit/miss statistics
module direct_mapped_cache #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 13,
  parameter int LINES  = 8,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic reset,
  direct_mapped_cache_if.slave bus
);
  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - INDEX_W;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [LINES-1:0][DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, dout_q, dout_d;
  logic hit_q, hit_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [INDEX_W-1:0] cpu_idx, cap_idx;
  logic [TAG_W-1:0] cpu_tag, cap_tag;
  logic cpu_hit;
  assign cpu_idx = bus.cpu_address[INDEX_W-1:0];
  assign cpu_tag = bus.cpu_address[ADDR_W-1:INDEX_W];
  assign cap_idx = addr_q[INDEX_W-1:0];
  assign cap_tag = addr_q[ADDR_W-1:INDEX_W];
  assign cpu_hit = valid_q[cpu_idx] && tag_q[cpu_idx] == cpu_tag;
  assign bus.cpu_dataOut = dout_q;
  assign bus.cpu_done = state_q == DONE;
  assign bus.mem_address = addr_q;
  assign bus.mem_dataIn = wdata_q;
  assign bus.mem_read = state_q == FILL;
  assign bus.mem_write = state_q == WRITE;
  assign bus.hit_count = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
  // next-state, line update and statistics; hit is judged only in IDLE and carried in hit_q
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    tag_d = tag_q;
    data_d = data_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    dout_d = dout_q;
    hit_d = hit_q;
    hit_cnt_d = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      IDLE:
        if (bus.flush) valid_d = '0;
        else if (bus.cpu_write) begin
          addr_d = bus.cpu_address;
          wdata_d = bus.cpu_dataIn;
          hit_d = cpu_hit;
          state_d = WRITE;
        end else if (bus.cpu_read && cpu_hit) begin
          dout_d = data_q[cpu_idx];
          hit_cnt_d = &hit_cnt_q ? hit_cnt_q : hit_cnt_q + CNT_W'(1);
          state_d = DONE;
        end else if (bus.cpu_read) begin
          addr_d = bus.cpu_address;
          miss_cnt_d = &miss_cnt_q ? miss_cnt_q : miss_cnt_q + CNT_W'(1);
          state_d = FILL;
        end
      FILL:
        if (bus.mem_done) begin
          valid_d[cap_idx] = 1'b1;
          tag_d[cap_idx] = cap_tag;
          data_d[cap_idx] = bus.mem_dataOut;
          dout_d = bus.mem_dataOut;
          state_d = DONE;
        end
      WRITE:
        if (bus.mem_done) begin
          data_d[cap_idx] = hit_q ? wdata_q : data_q[cap_idx];
          state_d = DONE;
        end
      default: state_d = IDLE;
    endcase
  end
  // state and storage registers; reset abandons any in-flight memory access
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      tag_q <= '0;
      data_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      dout_q <= '0;
      hit_q <= 1'b0;
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q <= tag_d;
      data_q <= data_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      dout_q <= dout_d;
      hit_q <= hit_d;
      hit_cnt_q <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
endmodule

// File: tb/tb_direct_mapped_cache.sv
// tb_direct_mapped_cache: randomized scoreboard bench for the direct-mapped cache
module tb_direct_mapped_cache;
  localparam int LINES = 8;
  localparam int CMAX = 15;
  typedef struct {
    bit rd;
    bit hit;
    logic [12:0] data;
    int hits;
    int misses;
    logic [12:0] addr;
    logic [12:0] wdata;
    int lat;
    int start;
  } exp_t;
  logic clk = 0;
  logic reset = 0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int mem_lat = 1;
  int mcnt = 0;
  int rd_cyc = 0;
  int wr_cyc = 0;
  bit prev_done = 0;
  logic [12:0] cap_a, cap_d;
  logic [12:0] mm [0:8191];
  logic [12:0] ref_mem [0:8191];
  bit mvalid [LINES];
  int mtag [LINES];
  int mhits, mmiss;
  logic [12:0] last_rd;
  exp_t q[$];
  direct_mapped_cache_if #(.ADDR_W(13), .DATA_W(13), .CNT_W(4)) bus ();
  direct_mapped_cache #(.ADDR_W(13), .DATA_W(13), .LINES(LINES), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask
  task automatic model_reset();
    for (int i = 0; i < LINES; i++) mvalid[i] = 0;
    mhits = 0;
    mmiss = 0;
    last_rd = '0;
  endtask
  // reference: line = addr mod LINES, tag = addr / LINES; read data always equals backing memory
  task automatic model_access(input bit rd, input bit wr, input logic [12:0] a, input logic [12:0] d, input int lat);
    exp_t e;
    int idx, tg;
    idx = int'(a) % LINES;
    tg = int'(a) / LINES;
    e.addr = a;
    e.wdata = d;
    e.lat = lat;
    e.start = cyc;
    if (wr) begin
      e.rd = 0;
      e.hit = 0;
      ref_mem[a] = d;
      e.data = last_rd;
    end else begin
      e.rd = 1;
      e.hit = mvalid[idx] && mtag[idx] == tg;
      if (e.hit) mhits = mhits < CMAX ? mhits + 1 : CMAX;
      else begin
        mmiss = mmiss < CMAX ? mmiss + 1 : CMAX;
        mvalid[idx] = 1;
        mtag[idx] = tg;
      end
      e.data = ref_mem[a];
      last_rd = e.data;
    end
    e.hits = mhits;
    e.misses = mmiss;
    q.push_back(e);
  endtask
  task automatic issue(input bit rd, input bit wr, input bit fl, input bit fm, input logic [12:0] a, input logic [12:0] d, input int lat);
    int n;
    @(negedge clk);
    mem_lat = lat;
    bus.cpu_address = a;
    bus.cpu_dataIn = d;
    bus.cpu_read = rd;
    bus.cpu_write = wr;
    bus.flush = fl;
    if (fl) begin
      for (int i = 0; i < LINES; i++) mvalid[i] = 0;
      @(negedge clk);
      bus.flush = 0;
    end
    if (rd || wr) begin
      model_access(rd, wr, a, d, lat);
      n = 0;
      do begin
        @(negedge clk);
        n++;
        bus.flush = fm && n == 2;
      end while (!bus.cpu_done && n < 64);
      bus.cpu_read = 0;
      bus.cpu_write = 0;
      bus.flush = 0;
      if (!bus.cpu_done) begin
        chk("done_timeout", 0, 1);
        summary();
      end
    end
  endtask
  // memory model: completes each strobed access after mem_lat cycles; data bus is noise otherwise
  always @(negedge clk) begin
    bus.mem_done = 0;
    bus.mem_dataOut = 13'($urandom);
    if (!reset || !(bus.mem_read || bus.mem_write)) mcnt = 0;
    else begin
      mcnt++;
      if (mcnt >= mem_lat) begin
        bus.mem_done = 1;
        bus.mem_dataOut = mm[bus.mem_address];
        if (bus.mem_write) mm[bus.mem_address] = bus.mem_dataIn;
        mcnt = 0;
      end
    end
  end
  // monitor: on each cpu_done pop the expected response and compare data, counters, traffic, latency
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      rd_cyc = 0;
      wr_cyc = 0;
      prev_done = 0;
    end else begin
      if (bus.mem_read || bus.mem_write) begin
        chk("strobe_exclusive", 32'(bus.mem_read & bus.mem_write), 0);
        cap_a = bus.mem_address;
        cap_d = bus.mem_dataIn;
      end
      rd_cyc += int'(bus.mem_read);
      wr_cyc += int'(bus.mem_write);
      if (prev_done) chk("done_one_cycle", 32'(bus.cpu_done), 0);
      if (bus.cpu_done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          chk(e.rd ? "read_data" : "data_hold", 32'(bus.cpu_dataOut), 32'(e.data));
          chk("hit_count", 32'(bus.hit_count), e.hits);
          chk("miss_count", 32'(bus.miss_count), e.misses);
          chk("mem_read_cycles", rd_cyc, (e.rd && !e.hit) ? e.lat : 0);
          chk("mem_write_cycles", wr_cyc, e.rd ? 0 : e.lat);
          chk("latency", cyc - e.start, (e.rd && e.hit) ? 1 : e.lat + 1);
          if (!(e.rd && e.hit)) chk("mem_address", 32'(cap_a), 32'(e.addr));
          if (!e.rd) chk("mem_dataIn", 32'(cap_d), 32'(e.wdata));
        end
        rd_cyc = 0;
        wr_cyc = 0;
      end
      prev_done = bus.cpu_done;
    end
  end
  initial begin
    int r, lat;
    logic [12:0] a, d;
    bus.cpu_address = 0;
    bus.cpu_dataIn = 0;
    bus.cpu_read = 0;
    bus.cpu_write = 0;
    bus.flush = 0;
    for (int i = 0; i < 8192; i++) begin
      mm[i] = 13'($urandom);
      ref_mem[i] = mm[i];
    end
    mm[5] = 13'h0F0;
    ref_mem[5] = 13'h0F0;
    model_reset();
    repeat (2) @(negedge clk);
    #2 reset = 1;
    issue(1, 0, 0, 0, 13'd5, 0, 3);
    issue(1, 0, 0, 0, 13'd5, 0, 2);
    issue(1, 0, 0, 0, 13'd13, 0, 2);
    issue(1, 0, 0, 0, 13'd5, 0, 2);
    issue(0, 1, 0, 0, 13'd5, 13'h1A5, 2);
    issue(1, 0, 0, 0, 13'd5, 0, 1);
    issue(0, 1, 0, 0, 13'd21, 13'h0C3, 1);
    issue(1, 0, 0, 0, 13'd21, 0, 2);
    issue(1, 0, 0, 0, 13'd5, 0, 1);
    issue(1, 0, 1, 0, 13'd5, 0, 2);
    issue(1, 0, 0, 1, 13'd13, 0, 4);
    issue(1, 0, 0, 0, 13'd13, 0, 1);
    issue(1, 1, 0, 0, 13'd6, 13'h055, 2);
    issue(0, 0, 1, 0, 0, 0, 1);
    @(negedge clk);
    mem_lat = 4;
    bus.cpu_address = 13'd9;
    bus.cpu_read = 1;
    repeat (2) @(negedge clk);
    chk("fill_in_progress", 32'(bus.mem_read), 1);
    #2 reset = 0;
    #1;
    chk("rst_dataOut", 32'(bus.cpu_dataOut), 0);
    chk("rst_done", 32'(bus.cpu_done), 0);
    chk("rst_mem_read", 32'(bus.mem_read), 0);
    chk("rst_mem_write", 32'(bus.mem_write), 0);
    chk("rst_mem_address", 32'(bus.mem_address), 0);
    chk("rst_mem_dataIn", 32'(bus.mem_dataIn), 0);
    chk("rst_hit_count", 32'(bus.hit_count), 0);
    chk("rst_miss_count", 32'(bus.miss_count), 0);
    bus.cpu_read = 0;
    q.delete();
    model_reset();
    @(negedge clk);
    #2 reset = 1;
    issue(1, 0, 0, 0, 13'd5, 0, 2);
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      a = 13'($urandom_range(0, 39));
      d = 13'($urandom);
      lat = $urandom_range(1, 4);
      issue(r < 65 || r >= 90, r >= 65 && r < 95, r >= 95, 0, a, d, lat);
    end
    for (int i = 0; i < 20; i++) issue(1, 0, 0, 0, 13'd5, 0, 1);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    summary();
  end
endmodule
